// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: one radix-2 shift-add or restoring-divide step per cycle.
// Optional macro MULDIV_EARLY_OUT_EN finishes divide-by-zero, signed overflow and zero-operand multiplies in one cycle.
module muldiv_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            start,
  input  logic            flush,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  localparam int CW = $clog2(XLEN + 1);
  localparam logic [XLEN-1:0] SMIN = {1'b1, {(XLEN-1){1'b0}}};

  state_t          state, state_nxt;
  logic [CW-1:0]   cnt;
  logic [2:0]      op;
  logic            neg_a, neg_b, dz, ovf;
  logic [XLEN-1:0] opnd, acc_hi, acc_lo, res_pend, res_q;

  logic            is_div_in, a_sgn_in, b_sgn_in, neg_a_in, neg_b_in;
  logic            dz_in, ovf_in, early_in, accept;
  logic [XLEN-1:0] a_mag_in, b_mag_in;

  logic signed [XLEN:0] mul_sum, div_shf, div_dif;
  logic [XLEN-1:0] hi_nxt, lo_nxt;

  // Sign correction and boundary overrides applied once, after the last iteration.
  function automatic logic [XLEN-1:0] finish_op(input logic [2:0] f, input logic na, input logic nb,
                                                input logic dzf, input logic ovff,
                                                input logic [XLEN-1:0] hi, input logic [XLEN-1:0] lo);
    logic signed [2*XLEN-1:0] prod;
    logic [XLEN-1:0] q, r;
    prod = {hi, lo};
    if (na ^ nb) prod = -prod;
    q = (na ^ nb) ? -lo : lo;
    // With a zero divisor the remainder register ends up holding |a|, so REM/REMU naturally return a.
    r = na ? -hi : hi;
    if (dzf) q = '1;
    if (ovff) begin
      q = SMIN;
      r = '0;
    end
    if (!f[2]) return (f[1:0] == 2'b00) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
    return f[1] ? r : q;
  endfunction

`ifdef MULDIV_EARLY_OUT_EN
  function automatic logic [XLEN-1:0] early_result(input logic [2:0] f, input logic dzf,
                                                   input logic [XLEN-1:0] av);
    if (!f[2]) return '0;
    if (dzf) return f[1] ? av : '1;
    return f[1] ? '0 : SMIN;
  endfunction
`endif

  always_comb begin
    is_div_in = funct3[2];
    a_sgn_in  = is_div_in ? ~funct3[0] : (funct3[1:0] != 2'b11);
    b_sgn_in  = is_div_in ? ~funct3[0] : ~funct3[1];
    neg_a_in  = a_sgn_in & a[XLEN-1];
    neg_b_in  = b_sgn_in & b[XLEN-1];
    a_mag_in  = neg_a_in ? -a : a;
    b_mag_in  = neg_b_in ? -b : b;
    dz_in     = is_div_in && (b == '0);
    ovf_in    = is_div_in && !funct3[0] && (a == SMIN) && (b == '1);
`ifdef MULDIV_EARLY_OUT_EN
    early_in  = dz_in || ovf_in || (!is_div_in && ((a == '0) || (b == '0)));
`else
    early_in  = 1'b0;
`endif
    accept    = (state == IDLE) && start && !flush;
  end

  // One iteration: shift-add for multiply, restoring subtract for divide.
  always_comb begin
    mul_sum = $signed({1'b0, acc_hi}) + $signed(acc_lo[0] ? {1'b0, opnd} : {(XLEN+1){1'b0}});
    div_shf = $signed({acc_hi, acc_lo[XLEN-1]});
    div_dif = div_shf - $signed({1'b0, opnd});
    if (op[2]) begin
      hi_nxt = div_dif[XLEN] ? div_shf[XLEN-1:0] : div_dif[XLEN-1:0];
      lo_nxt = {acc_lo[XLEN-2:0], ~div_dif[XLEN]};
    end else begin
      hi_nxt = mul_sum[XLEN:1];
      lo_nxt = {mul_sum[0], acc_lo[XLEN-1:1]};
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (accept) state_nxt = early_in ? DONE : BUSY;
      BUSY: begin
        if (flush)                state_nxt = IDLE;
        else if (cnt == CW'(1))   state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // A flush in DONE suppresses the pulse and leaves the previous result visible.
  always_comb begin
    busy   = (state != IDLE);
    done   = (state == DONE) && !flush;
    result = done ? res_pend : res_q;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cnt      <= '0;
      op       <= '0;
      neg_a    <= 1'b0;
      neg_b    <= 1'b0;
      dz       <= 1'b0;
      ovf      <= 1'b0;
      opnd     <= '0;
      acc_hi   <= '0;
      acc_lo   <= '0;
      res_pend <= '0;
      res_q    <= '0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          op     <= funct3;
          neg_a  <= neg_a_in;
          neg_b  <= neg_b_in;
          dz     <= dz_in;
          ovf    <= ovf_in;
          opnd   <= is_div_in ? b_mag_in : a_mag_in;
          acc_hi <= '0;
          acc_lo <= is_div_in ? a_mag_in : b_mag_in;
          cnt    <= CW'(XLEN);
`ifdef MULDIV_EARLY_OUT_EN
          if (early_in) res_pend <= early_result(funct3, dz_in, a);
`endif
        end
        BUSY: if (!flush) begin
          acc_hi <= hi_nxt;
          acc_lo <= lo_nxt;
          cnt    <= cnt - CW'(1);
          if (cnt == CW'(1)) res_pend <= finish_op(op, neg_a, neg_b, dz, ovf, hi_nxt, lo_nxt);
        end
        DONE: if (!flush) res_q <= res_pend;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: arithmetic vectors, boundary cases, latency, flush/reset aborts, back-to-back.
module tb_muldiv_unit;

  localparam int LAT = 33;
`ifdef MULDIV_EARLY_OUT_EN
  localparam int LAT_BZ = 1;
`else
  localparam int LAT_BZ = 33;
`endif

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic        flush = 1'b0;
  logic [2:0]  funct3 = 3'b000;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        busy, done;
  logic [31:0] result;

  int checks = 0;
  int errors = 0;

  muldiv_unit #(.XLEN(32)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .flush(flush),
    .funct3(funct3), .a(a), .b(b), .busy(busy), .done(done), .result(result)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Start one operation in the current cycle and return in its done cycle (or after a bound).
  task automatic run_op(input logic [2:0] f, input logic [31:0] av, input logic [31:0] bv,
                        output logic [31:0] res, output int lat,
                        output logic busy_ok, output logic hold_ok);
    logic [31:0] prev;
    prev = result;
    funct3 = f; a = av; b = bv; start = 1'b1;
    tick();
    start = 1'b0;
    lat = 1; busy_ok = 1'b1; hold_ok = 1'b1;
    while (done !== 1'b1 && lat < 60) begin
      if (busy !== 1'b1) busy_ok = 1'b0;
      if (result !== prev) hold_ok = 1'b0;
      tick();
      lat++;
    end
    if (busy !== 1'b1) busy_ok = 1'b0;
    res = result;
  endtask

  task automatic do_op(input string tag, input logic [2:0] f, input logic [31:0] av,
                       input logic [31:0] bv, input logic [31:0] exp, input int exp_lat);
    logic [31:0] res;
    int lat;
    logic bok, hok;
    run_op(f, av, bv, res, lat, bok, hok);
    check({tag, " result"}, res, exp);
    check({tag, " latency"}, 32'(lat), 32'(exp_lat));
    check({tag, " busy"}, {31'b0, bok}, 32'd1);
    tick();
    check({tag, " done pulse"}, {31'b0, done}, 32'd0);
    check({tag, " idle after"}, {31'b0, busy}, 32'd0);
    check({tag, " held"}, result, exp);
  endtask

  initial begin
    logic [31:0] r1, r2;
    int lat;
    logic bok, hok, seen;

    // Reset state
    tick(); tick();
    check("reset busy", {31'b0, busy}, 32'd0);
    check("reset done", {31'b0, done}, 32'd0);
    check("reset result", result, 32'd0);
    reset_n = 1'b1;
    tick();

    // Multiply family
    do_op("MUL 7*-3", 3'b000, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, LAT);
    do_op("MULH min*min", 3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, LAT);
    do_op("MULHU max*max", 3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, LAT);
    do_op("MULHSU -1*max", 3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, LAT);
    do_op("MUL 0*5", 3'b000, 32'd0, 32'd5, 32'd0, LAT_BZ);

    // Divide family
    do_op("DIV -7/2", 3'b100, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, LAT);
    do_op("REM -7%2", 3'b110, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, LAT);
    do_op("DIVU 100/7", 3'b101, 32'd100, 32'd7, 32'd14, LAT);
    do_op("REMU 100%7", 3'b111, 32'd100, 32'd7, 32'd2, LAT);

    // Boundary cases
    do_op("DIV 5/0", 3'b100, 32'd5, 32'd0, 32'hFFFF_FFFF, LAT_BZ);
    do_op("DIV -5/0", 3'b100, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFF, LAT_BZ);
    do_op("REM -5%0", 3'b110, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFB, LAT_BZ);
    do_op("DIV ovf", 3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, LAT_BZ);
    do_op("REM ovf", 3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, LAT_BZ);
    do_op("REMU 5%0", 3'b111, 32'd5, 32'd0, 32'd5, LAT_BZ);

    // Flush in cycle 10 of a DIV: no done, idle in cycle 11, result still 5
    funct3 = 3'b100; a = 32'd100; b = 32'd7; start = 1'b1;
    tick();
    start = 1'b0; seen = 1'b0;
    for (int i = 1; i < 10; i++) begin
      if (done === 1'b1) seen = 1'b1;
      tick();
    end
    flush = 1'b1;
    if (done === 1'b1) seen = 1'b1;
    tick();
    flush = 1'b0;
    check("flush idle c11", {31'b0, busy}, 32'd0);
    check("flush result c11", result, 32'd5);
    for (int i = 0; i < 40; i++) begin
      if (done === 1'b1) seen = 1'b1;
      tick();
    end
    check("flush no done", {31'b0, seen}, 32'd0);
    check("flush result kept", result, 32'd5);

    // start pulsed while busy is ignored
    funct3 = 3'b101; a = 32'd100; b = 32'd7; start = 1'b1;
    tick();
    start = 1'b0; lat = 1;
    for (int i = 1; i < 5; i++) begin tick(); lat++; end
    funct3 = 3'b000; a = 32'd3; b = 32'd3; start = 1'b1;
    tick(); lat++;
    start = 1'b0;
    while (done !== 1'b1 && lat < 60) begin tick(); lat++; end
    check("busy-start latency", 32'(lat), 32'd33);
    check("busy-start result", result, 32'd14);
    tick();
    check("busy-start not queued", {31'b0, busy}, 32'd0);

    // flush and start together in IDLE: nothing accepted
    funct3 = 3'b000; a = 32'd3; b = 32'd3; start = 1'b1; flush = 1'b1;
    tick();
    start = 1'b0; flush = 1'b0;
    check("flush+start busy", {31'b0, busy}, 32'd0);
    tick(); tick();
    check("flush+start result", result, 32'd14);

    // Back-to-back: second start in the cycle after done
    run_op(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, r1, lat, bok, hok);
    check("b2b first result", r1, 32'hFFFF_FFFE);
    tick();
    run_op(3'b000, 32'd7, 32'hFFFF_FFFD, r2, lat, bok, hok);
    check("b2b second latency", 32'(lat), 32'd33);
    check("b2b second result", r2, 32'hFFFF_FFEB);
    check("b2b first held", {31'b0, hok}, 32'd1);
    check("b2b busy", {31'b0, bok}, 32'd1);

    // Reset in cycle 10 of an operation
    funct3 = 3'b100; a = 32'd100; b = 32'd7; start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 1; i < 10; i++) tick();
    reset_n = 1'b0;
    tick();
    check("reset mid busy", {31'b0, busy}, 32'd0);
    check("reset mid done", {31'b0, done}, 32'd0);
    check("reset mid result", result, 32'd0);
    reset_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (done === 1'b1) seen = 1'b1;
      tick();
    end
    check("reset mid no done", {31'b0, seen}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
